sram_access_sequencer: RTL and testbench

Digital controller that sequences single-word read and write accesses to the team's analog SRAM test array. It generates the precharge, wordline, write-enable and sense-amp-enable phases with parameterised cycle counts, and presents a simple command/response handshake to the tile's I/O logic. It sits between the top-level pin mapping and the analog macro pins, and is the only block that drives the array's control strobes.

---
 rtl/sram_seq_pkg.sv | 35 +++
 rtl/sram_phase_timer.sv | 26 ++
 rtl/sram_access_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_sram_access_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
// Shared types and defaults for the SRAM access sequencer.
// The three verify states only exist when SRAM_SEQ_WRITE_VERIFY_EN is defined.
package sram_seq_pkg;

  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DATA_W     = 4;
  localparam int DEF_PRE_CYCLES = 2;
  localparam int DEF_WL_CYCLES  = 2;
  localparam int DEF_SAE_CYCLES = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_SENSE,
    S_RESP
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
    ,
    S_VPRE,
    S_VACT,
    S_VSENSE
`endif
  } seq_state_t;

  // The timer must hold the longest phase length; never narrower than one bit.
  function automatic int timer_width(input int pre, input int wl, input int sae);
    int m;
    m = pre;
    if (wl > m) m = wl;
    if (sae > m) m = sae;
    if ($clog2(m + 1) < 1) return 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times each sequencer phase.
// A load of N-1 on phase entry makes done rise in the phase's last cycle.
module sram_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_access_sequencer.sv
// Sequences precharge / wordline / write / sense phases for single-word SRAM accesses.
// Define SRAM_SEQ_WRITE_VERIFY_EN to add a read-back verify pass after every write.
module sram_access_sequencer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PRE_CYCLES = DEF_PRE_CYCLES,
  parameter int WL_CYCLES  = DEF_WL_CYCLES,
  parameter int SAE_CYCLES = DEF_SAE_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     sram_pre,
  output logic [(1<<ADDR_W)-1:0]   sram_wl,
  output logic                     sram_we,
  output logic [DATA_W-1:0]        sram_din,
  output logic                     sram_sae,
  input  logic [DATA_W-1:0]        sram_dout
);

  localparam int ROWS = 1 << ADDR_W;
  localparam int TW   = timer_width(PRE_CYCLES, WL_CYCLES, SAE_CYCLES);

  localparam logic [TW-1:0] PRE_LD = TW'(PRE_CYCLES - 1);
  localparam logic [TW-1:0] WL_LD  = TW'(WL_CYCLES - 1);
  localparam logic [TW-1:0] SAE_LD = TW'(SAE_CYCLES - 1);

  seq_state_t          state, state_next;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                accept;
  logic                phase_done, phase_load;
  logic [TW-1:0]       phase_len;
  logic                pre_d, we_d, sae_d, rsp_valid_d;
  logic [ROWS-1:0]     wl_d;
  logic [DATA_W-1:0]   din_d;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Strobes are registered from next-state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sram_pre  <= 1'b0;
      sram_wl   <= '0;
      sram_we   <= 1'b0;
      sram_din  <= '0;
      sram_sae  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      sram_pre  <= pre_d;
      sram_wl   <= wl_d;
      sram_we   <= we_d;
      sram_din  <= din_d;
      sram_sae  <= sae_d;
      rsp_valid <= rsp_valid_d;
      if (accept) begin
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (state == S_SENSE && phase_done)
        rsp_rdata <= sram_dout;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
      if (state == S_VSENSE && phase_done)
        rsp_rdata <= sram_dout;
`endif
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_PRE;
      S_PRE:    if (phase_done) state_next = S_ACT;
      S_ACT: begin
        if (phase_done) begin
          if (!we_q)
            state_next = S_SENSE;
          else begin
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
            state_next = S_VPRE;
`else
            state_next = S_RESP;
`endif
          end
        end
      end
      S_SENSE:  if (phase_done) state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
      S_VPRE:   if (phase_done) state_next = S_VACT;
      S_VACT:   if (phase_done) state_next = S_VSENSE;
      S_VSENSE: if (phase_done) state_next = S_RESP;
`endif
      default:  state_next = S_IDLE;
    endcase
  end

  assign phase_load = (state_next != state);

  always_comb begin
    phase_len = '0;
    case (state_next)
      S_PRE:    phase_len = PRE_LD;
      S_ACT:    phase_len = WL_LD;
      S_SENSE:  phase_len = SAE_LD;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
      S_VPRE:   phase_len = PRE_LD;
      S_VACT:   phase_len = WL_LD;
      S_VSENSE: phase_len = SAE_LD;
`endif
      default:  phase_len = '0;
    endcase
  end

  sram_phase_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (phase_load),
    .load_val (phase_len),
    .done     (phase_done)
  );

  always_comb begin
    pre_d       = 1'b0;
    we_d        = 1'b0;
    sae_d       = 1'b0;
    rsp_valid_d = 1'b0;
    wl_d        = '0;
    din_d       = '0;
    case (state_next)
      S_PRE:    pre_d = 1'b1;
      S_ACT: begin
        wl_d[addr_q] = 1'b1;
        we_d         = we_q;
        din_d        = we_q ? wdata_q : '0;
      end
      S_SENSE: begin
        wl_d[addr_q] = 1'b1;
        sae_d        = 1'b1;
      end
      S_RESP:   rsp_valid_d = 1'b1;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
      S_VPRE:   pre_d = 1'b1;
      S_VACT:   wl_d[addr_q] = 1'b1;
      S_VSENSE: begin
        wl_d[addr_q] = 1'b1;
        sae_d        = 1'b1;
      end
`endif
      default: begin
        pre_d = 1'b0;
      end
    endcase
  end

`ifdef SRAM_SEQ_WRITE_VERIFY_EN
  logic err_q;

  // Reads clear the flag; only a verify pass can raise it.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == S_SENSE && phase_done)
      err_q <= 1'b0;
    else if (state == S_VSENSE && phase_done)
      err_q <= (sram_dout != wdata_q);
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Self-checking bench for sram_access_sequencer: cycle-offset reference model plus directed literal checks.
// Honours SRAM_SEQ_WRITE_VERIFY_EN the same way the design does.
module tb_sram_access_sequencer;

  localparam int AW   = 3;
  localparam int DW   = 4;
  localparam int PRE  = 2;
  localparam int WL   = 2;
  localparam int SAE  = 1;
  localparam int ROWS = 8;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int RD_LAT = PRE + WL + SAE + 1;
  localparam int WR_LAT = VERIFY ? (2*PRE + 2*WL + SAE + 1) : (PRE + WL + 1);

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic            sram_pre;
  logic [ROWS-1:0] sram_wl;
  logic            sram_we;
  logic [DW-1:0]   sram_din;
  logic            sram_sae;
  logic [DW-1:0]   sram_dout;

  int checks = 0;
  int errors = 0;

  sram_access_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .PRE_CYCLES(PRE), .WL_CYCLES(WL), .SAE_CYCLES(SAE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .sram_pre  (sram_pre),
    .sram_wl   (sram_wl),
    .sram_we   (sram_we),
    .sram_din  (sram_din),
    .sram_sae  (sram_sae),
    .sram_dout (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int r);
    return DW'(r * 3 + 1);
  endfunction

  // Analog array stand-in: preloads on reset, stores on write strobe, optional stuck bits on readout.
  logic [DW-1:0] mem [ROWS];
  logic [DW-1:0] stuck_mask;

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= init_val(r);
    end else if (sram_we) begin
      for (int r = 0; r < ROWS; r++) if (sram_wl[r]) mem[r] <= sram_din;
    end
  end

  always_comb begin
    sram_dout = '0;
    for (int r = 0; r < ROWS; r++) if (sram_wl[r]) sram_dout = mem[r] & stuck_mask;
  end

  // Reference model: tracks one transaction by its start cycle and derives phases from the offset.
  int            cyc = 0;
  int            start = 0;
  bit            inflight = 1'b0;
  bit            checking = 1'b0;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] shadow [ROWS];
  logic [DW-1:0] exp_rdata = '0;
  bit            exp_err = 1'b0;

  always @(posedge clk) begin : model
    int  k_end;
    int  lat;
    bit  was_busy;
    k_end    = cyc - start + 1;
    was_busy = inflight;
    cyc++;
    if (rst) begin
      inflight  = 1'b0;
      exp_rdata = '0;
      exp_err   = 1'b0;
      checking  = 1'b1;
      for (int r = 0; r < ROWS; r++) shadow[r] = init_val(r);
    end else begin
      if (inflight) begin
        lat = m_we ? WR_LAT : RD_LAT;
        if (k_end == lat - 1 && (!m_we || VERIFY)) begin
          exp_rdata = shadow[m_addr] & stuck_mask;
          exp_err   = m_we && (exp_rdata != m_wdata);
        end
        if (k_end == lat) inflight = 1'b0;
      end
      if (!was_busy && cmd_valid) begin
        inflight = 1'b1;
        start    = cyc;
        m_we     = cmd_we;
        m_addr   = cmd_addr;
        m_wdata  = cmd_wdata;
        if (cmd_we) shadow[cmd_addr] = cmd_wdata;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Every cycle after the first reset edge, all outputs are compared with the model.
  always @(negedge clk) begin : compare
    int  k;
    int  lat;
    bit  p, a, va, s, vs, rv;
    logic [ROWS-1:0] wl_e;
    if (checking) begin
      p = 0; a = 0; va = 0; s = 0; vs = 0; rv = 0;
      if (inflight) begin
        k   = cyc - start + 1;
        lat = m_we ? WR_LAT : RD_LAT;
        p   = (k >= 1 && k <= PRE) || (VERIFY && m_we && k >= PRE+WL+1 && k <= 2*PRE+WL);
        a   = (k >= PRE+1 && k <= PRE+WL);
        va  = VERIFY && m_we && k >= 2*PRE+WL+1 && k <= 2*PRE+2*WL;
        s   = !m_we && k >= PRE+WL+1 && k <= PRE+WL+SAE;
        vs  = VERIFY && m_we && k >= 2*PRE+2*WL+1 && k <= 2*PRE+2*WL+SAE;
        rv  = (k == lat);
      end
      wl_e = (a || va || s || vs) ? ROWS'(1) << m_addr : '0;
      checkOutput("m_pre",   32'(sram_pre),  32'(p));
      checkOutput("m_wl",    32'(sram_wl),   32'(wl_e));
      checkOutput("m_we",    32'(sram_we),   32'(a && m_we));
      checkOutput("m_din",   32'(sram_din),  (a && m_we) ? 32'(m_wdata) : 32'd0);
      checkOutput("m_sae",   32'(sram_sae),  32'(s || vs));
      checkOutput("m_rsp",   32'(rsp_valid), 32'(rv));
      checkOutput("m_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      checkOutput("m_err",   32'(rsp_err),   32'(exp_err));
      checkOutput("m_busy",  32'(busy),      32'(inflight));
      checkOutput("m_ready", 32'(cmd_ready), 32'(!inflight && !rst));
    end
  end

  // Presents one command for exactly one acceptance edge; returns just after that edge.
  task automatic applyStimulus(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    checkOutput(name, 32'(idle), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit seen;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    stuck_mask = 4'hF;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pre",   32'(sram_pre),  32'd0);
    checkOutput("rst_wl",    32'(sram_wl),   32'd0);
    checkOutput("rst_busy",  32'(busy),      32'd0);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Write addr 5, data 0xA
    applyStimulus(1'b1, 3'd5, 4'hA);
    @(negedge clk);
    checkOutput("wr_c1_pre", 32'(sram_pre), 32'd1);
    checkOutput("wr_c1_wl",  32'(sram_wl),  32'd0);
    repeat (2) @(negedge clk);
    checkOutput("wr_c3_wl",  32'(sram_wl),  32'h20);
    checkOutput("wr_c3_we",  32'(sram_we),  32'd1);
    checkOutput("wr_c3_din", 32'(sram_din), 32'hA);
    checkOutput("wr_c3_pre", 32'(sram_pre), 32'd0);
    repeat (WR_LAT - 3) @(negedge clk);
    checkOutput("wr_rsp", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    checkOutput("wr_rsp_gone", 32'(rsp_valid), 32'd0);

    // Read addr 5 back
    applyStimulus(1'b0, 3'd5, 4'h0);
    repeat (5) @(negedge clk);
    checkOutput("rd_c5_sae", 32'(sram_sae), 32'd1);
    checkOutput("rd_c5_wl",  32'(sram_wl),  32'h20);
    @(negedge clk);
    checkOutput("rd_rsp",   32'(rsp_valid), 32'd1);
    checkOutput("rd_rdata", 32'(rsp_rdata), 32'hA);

    // cmd_valid held high with the address and data drifting every cycle
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 3'd2; cmd_wdata = 4'h3;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      cmd_addr  = cmd_addr + 3'd1;
      cmd_wdata = cmd_wdata + 4'd5;
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("hold_rsp_seen", 32'(seen),      32'd1);
    checkOutput("hold_rdata",    32'(rsp_rdata), 32'h7);
    @(negedge clk);
    checkOutput("hold_ready_next", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    checkOutput("hold_second_busy", 32'(busy),     32'd1);
    checkOutput("hold_second_pre",  32'(sram_pre), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    waitIdle("hold_idle");

    // Reset during the ACT phase of a write
    applyStimulus(1'b1, 3'd3, 4'h6);
    repeat (3) @(negedge clk);
    checkOutput("abort_c3_we", 32'(sram_we), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_pre", 32'(sram_pre),  32'd0);
    checkOutput("abort_wl",  32'(sram_wl),   32'd0);
    checkOutput("abort_we",  32'(sram_we),   32'd0);
    checkOutput("abort_sae", 32'(sram_sae),  32'd0);
    checkOutput("abort_rsp", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 3'd4, 4'h0);
    repeat (RD_LAT) @(negedge clk);
    checkOutput("post_abort_rsp",   32'(rsp_valid), 32'd1);
    checkOutput("post_abort_rdata", 32'(rsp_rdata), 32'hD);

`ifdef SRAM_SEQ_WRITE_VERIFY_EN
    // Verify pass with bit 0 of the array stuck low
    @(negedge clk);
    stuck_mask = 4'hE;
    applyStimulus(1'b1, 3'd1, 4'h5);
    repeat (10) @(negedge clk);
    checkOutput("vfy_rsp",   32'(rsp_valid), 32'd1);
    checkOutput("vfy_err",   32'(rsp_err),   32'd1);
    checkOutput("vfy_rdata", 32'(rsp_rdata), 32'h4);
    @(negedge clk);
    stuck_mask = 4'hF;
    applyStimulus(1'b0, 3'd1, 4'h0);
    repeat (RD_LAT) @(negedge clk);
    checkOutput("vfy_rd_rsp",   32'(rsp_valid), 32'd1);
    checkOutput("vfy_rd_err",   32'(rsp_err),   32'd0);
    checkOutput("vfy_rd_rdata", 32'(rsp_rdata), 32'h5);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
